tm1638_responder: RTL and testbench
===================================

# tm1638_responder

Synthesizable TM1638-style serial responder: the device end of the three-wire Stb/Clk/Dio link that our SPI command master drives. It oversamples the link on the system clock, decodes command, address and data bytes into single-cycle write and control strobes, and returns a key-scan word on Dio for read commands. It serves as an on-FPGA loopback target for the master, and as the front end for a display/keypad emulator.

## Interface
- READ_WIDTH, 32: key-scan bits returned per read command; must be a power of 2 and at least 8.
- SYNC_STAGES, 2: synchronizer depth on each input pin; must be at least 2.

- i_Clk  in  1  system clock; the only clock.
- i_Rst  in  1  synchronous, active-high reset.
- i_SPI_Stb  in  1  strobe, active low; a frame is Stb low.
- i_SPI_Clk  in  1  serial clock; idles high.
- i_SPI_Dio  in  1  data in (pin input side).
- o_SPI_Dio  out  1  data out (pin output side).
- o_SPI_Dio_En  out  1  output enable; the top level builds the tristate.
- i_Keys  in  READ_WIDTH  key-scan word, sampled when a read command completes.
- o_Keys_Read  out  1  1-cycle pulse when i_Keys is latched.
- o_Wr_Valid  out  1  1-cycle pulse: display RAM write.
- o_Wr_Addr  out  4  write address; valid with o_Wr_Valid.
- o_Wr_Data  out  8  write data; valid with o_Wr_Valid.
- o_Ctrl_Valid  out  1  1-cycle pulse: display control byte received.
- o_Ctrl  out  4  bit3 = display on, bits 2:0 = brightness; holds its last value.
- o_Frame_Err  out  1  1-cycle pulse on a protocol error.

## Operation
- **Pin conditioning.** Each pin passes through SYNC_STAGES flops. Stb and Clk synchronizers reset to 1; Dio resets to 0. Edges are detected from the last synchronizer stage against a one-flop delayed copy.
- **Bit order and sampling.** Bits arrive LSB first and are sampled on the SPI Clk rising edge. The 8-bit shift register shifts right, with the new bit entering bit 7. A 3-bit counter completes a byte on its 8th rising edge.
- **States:** IDLE, CMD, DATA, READ, IGNORE.
- **Frame start.** A Stb falling edge, from any state, clears the bit counter and enters CMD. Clk edges are ignored while synchronized Stb is high.
- **CMD byte complete**, decoded on b[7:6]:
  - 01, b[1]=1 (read, 0x42): latch i_Keys, pulse o_Keys_Read, go to READ.
  - 01, b[1]=0 (0x40 / 0x44): r_Fixed <= b[2]; go to IGNORE. r_Fixed persists across frames.
  - 11 (0xC0–0xCF): r_Addr <= b[3:0]; go to DATA.
  - 10 (0x80–0x8F): o_Ctrl <= b[3:0]; pulse o_Ctrl_Valid; go to IGNORE.
  - 00: pulse o_Frame_Err; go to IGNORE.
- **DATA byte complete.** Pulse o_Wr_Valid with o_Wr_Addr = r_Addr and o_Wr_Data = byte. Then r_Addr <= r_Addr+1 (wraps 15→0) unless r_Fixed.
- **IGNORE byte complete:** pulse o_Frame_Err.
- **READ.** On each Clk falling edge k (k = 0..READ_WIDTH-1): o_SPI_Dio_En <= 1, o_SPI_Dio <= latched bit k. After the rising edge that follows bit READ_WIDTH-1, drop En; any further falling edges do not re-enable it.
- **Frame end.** On a Stb rising edge:
  - pulse o_Frame_Err if the bit counter is nonzero and the state is not READ; the partial byte is discarded;
  - drop En;
  - go to IDLE.
- **Simultaneous events.** Stb and Clk edges detected in the same cycle: the Stb edge wins, and the Clk edge is dropped.

## Timing
- **Reset values:** all outputs 0; state IDLE; r_Addr = 0; r_Fixed = 0; o_Ctrl = 0.
- **Pin-to-action latency** is SYNC_STAGES+1 i_Clk cycles. Strobes fire on the cycle after the 8th rising edge is detected, for exactly one cycle.
- **Speed requirement:** SPI Clk high and low phases are each at least SYNC_STAGES+2 i_Clk cycles. Slower is always correct.
- **Read turnaround.** Master Dio must be released before the first falling edge after the read command. Dio is valid SYNC_STAGES+2 cycles after each falling edge at the pin.
- **Reset mid-frame** returns to IDLE and drops En. The rest of the frame is ignored until the next Stb falling edge.

## Test plan
- Frame 0x40 | 0xC3, 0x11, 0x22, 0x33 -> o_Wr_Valid ×3 at addresses 3, 4, 5 with data 0x11, 0x22, 0x33; no o_Frame_Err.
- Frame 0x44, then frame 0xCF, 0xAA, 0xBB -> writes (15, 0xAA) and (15, 0xBB). Repeat with 0x40 -> addresses 15, 0 (wrap).
- Frame 0x8A -> o_Ctrl = 4'hA with a single o_Ctrl_Valid pulse. A second byte 0x00 in the same frame -> one o_Frame_Err pulse.
- Frame 0x42 with i_Keys = 32'h8000_0001 -> o_Keys_Read pulse, then 32 bits on Dio read LSB first = 32'h8000_0001. En is 0 before the first falling edge and after the last bit.
- Stb raised after 5 bits of a data byte -> one o_Frame_Err, no o_Wr_Valid. The next frame 0xC0, 0x55 -> write (0, 0x55).
- i_Rst asserted mid-DATA byte with Stb held low, then 8 more clocks -> no strobes. After Stb high→low and frame 0xC1, 0x77 -> write (1, 0x77).

Source files
------------

// File: rtl/tm1638_responder_if.sv
// Three-wire TM1638 link (Stb/Clk/Dio) between the command master and the responder.
// Dio is split into the pin input side and the output/enable pair; the top level
// builds the tristate.
interface tm1638_responder_if;
    logic SPI_Stb;
    logic SPI_Clk;
    logic SPI_Dio_In;
    logic SPI_Dio_Out;
    logic SPI_Dio_En;

    modport master (
        output SPI_Stb,
        output SPI_Clk,
        output SPI_Dio_In,
        input  SPI_Dio_Out,
        input  SPI_Dio_En
    );

    modport slave (
        input  SPI_Stb,
        input  SPI_Clk,
        input  SPI_Dio_In,
        output SPI_Dio_Out,
        output SPI_Dio_En
    );
endinterface

// File: rtl/tm1638_responder.sv
// TM1638-style serial responder: oversamples Stb/Clk/Dio on i_Clk, decodes
// command/address/data bytes into single-cycle strobes and shifts a key-scan
// word back out on Dio for read commands.
//
// state  | meaning
// IDLE   | no frame open (Stb high, or reset seen mid-frame)
// CMD    | collecting the command byte
// DATA   | collecting display RAM write bytes
// READ   | driving the latched key-scan word on falling edges
// IGNORE | any further byte in this frame is a protocol error
module tm1638_responder #(
    parameter int READ_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    tm1638_responder_if.slave     spi,
    input  logic [READ_WIDTH-1:0] i_Keys,
    output logic                  o_Keys_Read,
    output logic                  o_Wr_Valid,
    output logic [3:0]            o_Wr_Addr,
    output logic [7:0]            o_Wr_Data,
    output logic                  o_Ctrl_Valid,
    output logic [3:0]            o_Ctrl,
    output logic                  o_Frame_Err
);
    localparam int IDX_W = $clog2(READ_WIDTH);

    typedef enum logic [2:0] {IDLE, CMD, DATA, READ, IGNORE} state_t;

    state_t r_State, w_State_Nxt;

    logic [SYNC_STAGES-1:0] r_Stb_Sync, r_Clk_Sync, r_Dio_Sync;
    logic                   r_Stb_D, r_Clk_D;
    logic [SYNC_STAGES:0]   r_Warm;
    logic [2:0]             r_Bit_Cnt;
    logic [7:0]             r_Shift;
    logic [3:0]             r_Addr;
    logic                   r_Fixed;
    logic [READ_WIDTH-1:0]  r_Keys;
    logic [IDX_W-1:0]       r_Rd_Idx;
    logic                   r_Rd_Done;
    logic                   r_Dout, r_En;

    logic w_Stb, w_Clk, w_Dio, w_Live;
    logic w_Stb_Fall, w_Stb_Rise, w_Stb_Edge, w_Clk_Rise, w_Clk_Fall;
    logic w_Shift_State, w_Byte_Done;
    logic [7:0] w_Byte;
    logic w_Wr_Go, w_Ctrl_Go, w_Keys_Go, w_Err_Go, w_Fixed_Ld, w_Addr_Ld;

    assign w_Stb = r_Stb_Sync[SYNC_STAGES-1];
    assign w_Clk = r_Clk_Sync[SYNC_STAGES-1];
    assign w_Dio = r_Dio_Sync[SYNC_STAGES-1];

    // Edges are masked until the synchronizers have flushed their reset values,
    // so a Stb held low through reset is not mistaken for a new frame.
    assign w_Live        = r_Warm[SYNC_STAGES];
    assign w_Stb_Fall    = w_Live & r_Stb_D & ~w_Stb;
    assign w_Stb_Rise    = w_Live & ~r_Stb_D & w_Stb;
    assign w_Stb_Edge    = w_Stb_Fall | w_Stb_Rise;
    assign w_Clk_Rise    = w_Live & ~r_Clk_D & w_Clk & ~w_Stb & ~w_Stb_Edge;
    assign w_Clk_Fall    = w_Live & r_Clk_D & ~w_Clk & ~w_Stb & ~w_Stb_Edge;
    assign w_Shift_State = (r_State == CMD) || (r_State == DATA) || (r_State == IGNORE);
    assign w_Byte        = {w_Dio, r_Shift[7:1]};
    assign w_Byte_Done   = w_Clk_Rise && w_Shift_State && (r_Bit_Cnt == 3'd7);

    assign spi.SPI_Dio_Out = r_Dout;
    assign spi.SPI_Dio_En  = r_En;

    // Pin synchronizers, delayed copies for edge detection, and warm-up mask.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Stb_Sync <= '1;
            r_Clk_Sync <= '1;
            r_Dio_Sync <= '0;
            r_Stb_D    <= 1'b1;
            r_Clk_D    <= 1'b1;
            r_Warm     <= '0;
        end else begin
            r_Stb_Sync <= {r_Stb_Sync[SYNC_STAGES-2:0], spi.SPI_Stb};
            r_Clk_Sync <= {r_Clk_Sync[SYNC_STAGES-2:0], spi.SPI_Clk};
            r_Dio_Sync <= {r_Dio_Sync[SYNC_STAGES-2:0], spi.SPI_Dio_In};
            r_Stb_D    <= w_Stb;
            r_Clk_D    <= w_Clk;
            r_Warm     <= {r_Warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) r_State <= IDLE;
        else       r_State <= w_State_Nxt;
    end

    // Next-state and byte decode; Stb edges take priority over byte completion.
    always_comb begin
        w_State_Nxt = r_State;
        w_Wr_Go     = 1'b0;
        w_Ctrl_Go   = 1'b0;
        w_Keys_Go   = 1'b0;
        w_Err_Go    = 1'b0;
        w_Fixed_Ld  = 1'b0;
        w_Addr_Ld   = 1'b0;
        if (w_Stb_Fall) begin
            w_State_Nxt = CMD;
        end else if (w_Stb_Rise) begin
            w_State_Nxt = IDLE;
            w_Err_Go    = (r_Bit_Cnt != 3'd0) && (r_State != READ);
        end else if (w_Byte_Done) begin
            case (r_State)
                CMD: begin
                    case (w_Byte[7:6])
                        2'b01: begin
                            if (w_Byte[1]) begin
                                w_Keys_Go   = 1'b1;
                                w_State_Nxt = READ;
                            end else begin
                                w_Fixed_Ld  = 1'b1;
                                w_State_Nxt = IGNORE;
                            end
                        end
                        2'b11: begin
                            w_Addr_Ld   = 1'b1;
                            w_State_Nxt = DATA;
                        end
                        2'b10: begin
                            w_Ctrl_Go   = 1'b1;
                            w_State_Nxt = IGNORE;
                        end
                        default: begin
                            w_Err_Go    = 1'b1;
                            w_State_Nxt = IGNORE;
                        end
                    endcase
                end
                DATA:    w_Wr_Go  = 1'b1;
                IGNORE:  w_Err_Go = 1'b1;
                default: ;
            endcase
        end
    end

    // Byte shifter, register file updates, output strobes and the read shifter.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Bit_Cnt    <= '0;
            r_Shift      <= '0;
            r_Addr       <= '0;
            r_Fixed      <= 1'b0;
            r_Keys       <= '0;
            r_Rd_Idx     <= '0;
            r_Rd_Done    <= 1'b0;
            r_Dout       <= 1'b0;
            r_En         <= 1'b0;
            o_Keys_Read  <= 1'b0;
            o_Wr_Valid   <= 1'b0;
            o_Wr_Addr    <= '0;
            o_Wr_Data    <= '0;
            o_Ctrl_Valid <= 1'b0;
            o_Ctrl       <= '0;
            o_Frame_Err  <= 1'b0;
        end else begin
            o_Wr_Valid   <= w_Wr_Go;
            o_Ctrl_Valid <= w_Ctrl_Go;
            o_Keys_Read  <= w_Keys_Go;
            o_Frame_Err  <= w_Err_Go;

            if (w_Stb_Edge) begin
                r_Bit_Cnt <= '0;
            end else if (w_Clk_Rise && w_Shift_State) begin
                r_Bit_Cnt <= r_Bit_Cnt + 3'd1;
                r_Shift   <= w_Byte;
            end

            if (w_Wr_Go) begin
                o_Wr_Addr <= r_Addr;
                o_Wr_Data <= w_Byte;
                if (!r_Fixed) r_Addr <= r_Addr + 4'd1;
            end
            if (w_Addr_Ld)  r_Addr  <= w_Byte[3:0];
            if (w_Fixed_Ld) r_Fixed <= w_Byte[2];
            if (w_Ctrl_Go)  o_Ctrl  <= w_Byte[3:0];
            if (w_Keys_Go) begin
                r_Keys    <= i_Keys;
                r_Rd_Idx  <= '0;
                r_Rd_Done <= 1'b0;
            end

            if (w_Stb_Edge) begin
                r_En <= 1'b0;
            end else if (r_State == READ) begin
                if (w_Clk_Fall && !r_Rd_Done) begin
                    r_En   <= 1'b1;
                    r_Dout <= r_Keys[r_Rd_Idx];
                end else if (w_Clk_Rise && r_En) begin
                    if (r_Rd_Idx == IDX_W'(READ_WIDTH - 1)) begin
                        r_Rd_Done <= 1'b1;
                        r_En      <= 1'b0;
                    end else begin
                        r_Rd_Idx <= r_Rd_Idx + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: a table of write/control frames plus
// hand-written read, aborted-frame and mid-frame-reset sequences.
module tb_tm1638_responder;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] keys;
    logic        keys_read, wr_valid, ctrl_valid, frame_err;
    logic [3:0]  wr_addr, ctrl;
    logic [7:0]  wr_data;

    tm1638_responder_if spi_if();

    tm1638_responder #(.READ_WIDTH(32), .SYNC_STAGES(2)) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .spi          (spi_if),
        .i_Keys       (keys),
        .o_Keys_Read  (keys_read),
        .o_Wr_Valid   (wr_valid),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_Data    (wr_data),
        .o_Ctrl_Valid (ctrl_valid),
        .o_Ctrl       (ctrl),
        .o_Frame_Err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_wr, n_err, n_ctrl, n_keys;
    logic [3:0] wr_a[$];
    logic [7:0] wr_d[$];

    // Strobe monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (wr_valid) begin
            n_wr++;
            wr_a.push_back(wr_addr);
            wr_d.push_back(wr_data);
        end
        if (frame_err)  n_err++;
        if (ctrl_valid) n_ctrl++;
        if (keys_read)  n_keys++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_mon();
        @(posedge clk);
        n_wr = 0; n_err = 0; n_ctrl = 0; n_keys = 0;
        wr_a.delete();
        wr_d.delete();
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            spi_if.SPI_Clk    = 1'b0;
            spi_if.SPI_Dio_In = b[i];
            wait_cyc(H);
            spi_if.SPI_Clk = 1'b1;
            wait_cyc(H);
        end
    endtask

    task automatic frame_start();
        spi_if.SPI_Stb = 1'b0;
        wait_cyc(H);
    endtask

    task automatic frame_end();
        wait_cyc(H);
        spi_if.SPI_Stb = 1'b1;
        wait_cyc(2 * H);
    endtask

    task automatic chk_one_write(input string name, input logic [3:0] a, input logic [7:0] d);
        chk({name, "_count"}, n_wr, 1);
        if (wr_a.size() > 0) begin
            chk({name, "_addr"}, {28'd0, wr_a[0]}, {28'd0, a});
            chk({name, "_data"}, {24'd0, wr_d[0]}, {24'd0, d});
        end
    endtask

    typedef struct packed {
        logic [2:0]  nb;
        logic [31:0] bytes;   // first byte in [7:0]
        logic [1:0]  nwr;
        logic [11:0] addrs;   // first write address in [3:0]
        logic [23:0] datas;   // first write data in [7:0]
        logic [1:0]  nerr;
        logic        nctrl;
        logic [3:0]  ctrl;    // o_Ctrl after the frame
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{3'd1, 32'h0000_0040, 2'd0, 12'h000, 24'h000000, 2'd0, 1'b0, 4'h0};
        vecs[1] = '{3'd4, 32'h3322_11C3, 2'd3, 12'h543, 24'h332211, 2'd0, 1'b0, 4'h0};
        vecs[2] = '{3'd1, 32'h0000_0044, 2'd0, 12'h000, 24'h000000, 2'd0, 1'b0, 4'h0};
        vecs[3] = '{3'd3, 32'h00BB_AACF, 2'd2, 12'h0FF, 24'h00BBAA, 2'd0, 1'b0, 4'h0};
        vecs[4] = '{3'd1, 32'h0000_0040, 2'd0, 12'h000, 24'h000000, 2'd0, 1'b0, 4'h0};
        vecs[5] = '{3'd3, 32'h00BB_AACF, 2'd2, 12'h00F, 24'h00BBAA, 2'd0, 1'b0, 4'h0};
        vecs[6] = '{3'd1, 32'h0000_008A, 2'd0, 12'h000, 24'h000000, 2'd0, 1'b1, 4'hA};
        vecs[7] = '{3'd2, 32'h0000_0083, 2'd0, 12'h000, 24'h000000, 2'd1, 1'b1, 4'h3};
        vecs[8] = '{3'd1, 32'h0000_0000, 2'd0, 12'h000, 24'h000000, 2'd1, 1'b0, 4'h3};

        rst = 1'b1;
        keys = 32'h0;
        spi_if.SPI_Stb    = 1'b1;
        spi_if.SPI_Clk    = 1'b1;
        spi_if.SPI_Dio_In = 1'b0;
        wait_cyc(5);
        @(negedge clk);
        chk("rst_wr_valid", {31'd0, wr_valid}, 0);
        chk("rst_ctrl", {28'd0, ctrl}, 0);
        chk("rst_en", {31'd0, spi_if.SPI_Dio_En}, 0);
        chk("rst_dio", {31'd0, spi_if.SPI_Dio_Out}, 0);
        chk("rst_err", {31'd0, frame_err}, 0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 0);
        rst = 1'b0;
        wait_cyc(5);

        for (int v = 0; v < 9; v++) begin
            clear_mon();
            frame_start();
            for (int j = 0; j < int'(vecs[v].nb); j++) spi_bits(vecs[v].bytes[8*j +: 8], 8);
            frame_end();
            @(negedge clk);
            chk($sformatf("v%0d_wr_count", v), n_wr, {30'd0, vecs[v].nwr});
            for (int k = 0; k < int'(vecs[v].nwr); k++) begin
                if (k < wr_a.size()) begin
                    chk($sformatf("v%0d_addr%0d", v, k), {28'd0, wr_a[k]}, {28'd0, vecs[v].addrs[4*k +: 4]});
                    chk($sformatf("v%0d_data%0d", v, k), {24'd0, wr_d[k]}, {24'd0, vecs[v].datas[8*k +: 8]});
                end
            end
            chk($sformatf("v%0d_err", v), n_err, {30'd0, vecs[v].nerr});
            chk($sformatf("v%0d_ctrl_valid", v), n_ctrl, {31'd0, vecs[v].nctrl});
            chk($sformatf("v%0d_ctrl", v), {28'd0, ctrl}, {28'd0, vecs[v].ctrl});
        end

        // Read frames: key word shifted out LSB first on falling edges.
        for (int r = 0; r < 2; r++) begin
            logic [31:0] rd;
            logic        en_ok;
            keys = (r == 0) ? 32'h8000_0001 : 32'h1234_5678;
            clear_mon();
            frame_start();
            spi_bits(8'h42, 8);
            @(negedge clk);
            chk($sformatf("rd%0d_keys_read", r), n_keys, 1);
            chk($sformatf("rd%0d_en_before", r), {31'd0, spi_if.SPI_Dio_En}, 0);
            rd = '0;
            en_ok = 1'b1;
            for (int k = 0; k < 32; k++) begin
                spi_if.SPI_Clk = 1'b0;
                wait_cyc(H);
                @(negedge clk);
                rd[k] = spi_if.SPI_Dio_Out;
                if (spi_if.SPI_Dio_En !== 1'b1) en_ok = 1'b0;
                spi_if.SPI_Clk = 1'b1;
                wait_cyc(H);
            end
            chk($sformatf("rd%0d_word", r), rd, keys);
            chk($sformatf("rd%0d_en_during", r), {31'd0, en_ok}, 1);
            @(negedge clk);
            chk($sformatf("rd%0d_en_after", r), {31'd0, spi_if.SPI_Dio_En}, 0);
            spi_if.SPI_Clk = 1'b0;
            wait_cyc(H);
            @(negedge clk);
            chk($sformatf("rd%0d_en_extra_fall", r), {31'd0, spi_if.SPI_Dio_En}, 0);
            spi_if.SPI_Clk = 1'b1;
            wait_cyc(H);
            frame_end();
            @(negedge clk);
            chk($sformatf("rd%0d_err", r), n_err, 0);
            chk($sformatf("rd%0d_wr", r), n_wr, 0);
        end

        // Frame aborted after 5 bits of a data byte.
        clear_mon();
        frame_start();
        spi_bits(8'hC0, 8);
        spi_bits(8'h1F, 5);
        frame_end();
        @(negedge clk);
        chk("abort_err", n_err, 1);
        chk("abort_wr", n_wr, 0);
        clear_mon();
        frame_start();
        spi_bits(8'hC0, 8);
        spi_bits(8'h55, 8);
        frame_end();
        @(negedge clk);
        chk_one_write("after_abort", 4'h0, 8'h55);
        chk("after_abort_err", n_err, 0);

        // Reset in the middle of a data byte with Stb still low.
        clear_mon();
        frame_start();
        spi_bits(8'hC2, 8);
        spi_bits(8'hFF, 3);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        spi_bits(8'hFF, 8);
        @(negedge clk);
        chk("rst_mid_wr", n_wr, 0);
        chk("rst_mid_err", n_err, 0);
        chk("rst_mid_en", {31'd0, spi_if.SPI_Dio_En}, 0);
        frame_end();
        @(negedge clk);
        chk("rst_mid_end_err", n_err, 0);
        clear_mon();
        frame_start();
        spi_bits(8'hC1, 8);
        spi_bits(8'h77, 8);
        frame_end();
        @(negedge clk);
        chk_one_write("after_rst", 4'h1, 8'h77);
        chk("after_rst_err", n_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
